// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin sensor synchronizer, debouncer and spaced credit pulse issuer (optional macro COIN_COUNT_EN)
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int GAP        = 2
) (
  input  logic       clk,
  input  logic       rst,
`ifdef COIN_COUNT_EN
  input  logic       clear_cnt,
`endif
  input  logic       n_raw,
  input  logic       d_raw,
  output logic       N,
  output logic       D,
  output logic       rej
`ifdef COIN_COUNT_EN
  ,
  output logic [7:0] n_count,
  output logic [7:0] d_count
`endif
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam int GW = $clog2(GAP + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  // Channel index 0 is the nickel sensor, index 1 the dime sensor.
  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } deb_state_t;

  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  deb_state_t    r_state     [2];
  deb_state_t    w_state_nxt [2];
  logic [CW-1:0] r_cnt       [2];
  logic [CW-1:0] w_cnt_nxt   [2];
  logic [1:0]    w_strobe;
  logic [1:0]    r_q;

  logic          r_slot_full;
  logic          r_slot_dime;
  logic [GW-1:0] r_gap;
  logic          r_n_pulse;
  logic          r_d_pulse;
  logic          r_rej;

  logic          w_issue;
  logic          w_both;
  logic          w_one;
  logic          w_accept;
  logic          w_rej_nxt;
  logic          w_slot_full_nxt;
  logic          w_slot_dime_nxt;
  logic [GW-1:0] w_gap_nxt;

  // Two-flop synchronizer on both raw sensor lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {d_raw, n_raw};
      r_sync2 <= r_sync1;
    end
  end

  // Debounce state and hold counter registers; strobe is registered so it lasts one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= ST_LOW;
        r_cnt[i]   <= '0;
      end
      r_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_q <= w_strobe;
    end
  end

  // Debounce next state: a level must hold DEB_CYCLES synchronized cycles; only LOW->HIGH strobes.
  always_comb begin
    w_strobe = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_LOW: begin
          if (r_sync2[i]) begin
            w_state_nxt[i] = ST_RISE;
            w_cnt_nxt[i]   = CNT_ONE;
          end
        end
        ST_RISE: begin
          if (!r_sync2[i]) begin
            w_state_nxt[i] = ST_LOW;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = ST_HIGH;
            w_strobe[i]    = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!r_sync2[i]) begin
            w_state_nxt[i] = ST_FALL;
            w_cnt_nxt[i]   = CNT_ONE;
          end
        end
        ST_FALL: begin
          if (r_sync2[i]) begin
            w_state_nxt[i] = ST_HIGH;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = ST_LOW;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_LOW;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Arbitration and issue: a strobe may refill the slot in the same cycle it is being issued.
  always_comb begin
    w_issue         = r_slot_full && (r_gap == '0);
    w_both          = r_q[0] && r_q[1];
    w_one           = r_q[0] ^ r_q[1];
    w_accept        = w_one && (!r_slot_full || w_issue);
    w_rej_nxt       = w_both || (w_one && r_slot_full && !w_issue);
    w_slot_full_nxt = r_slot_full;
    w_slot_dime_nxt = r_slot_dime;
    w_gap_nxt       = r_gap;
    if (w_accept) begin
      w_slot_full_nxt = 1'b1;
      w_slot_dime_nxt = r_q[1];
    end else if (w_issue) begin
      w_slot_full_nxt = 1'b0;
    end
    if (w_issue) begin
      w_gap_nxt = GAP_LOAD;
    end else if (r_gap != '0) begin
      w_gap_nxt = r_gap - GAP_ONE;
    end
  end

  // Pending slot, gap counter and registered output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot_full <= 1'b0;
      r_slot_dime <= 1'b0;
      r_gap       <= '0;
      r_n_pulse   <= 1'b0;
      r_d_pulse   <= 1'b0;
      r_rej       <= 1'b0;
    end else begin
      r_slot_full <= w_slot_full_nxt;
      r_slot_dime <= w_slot_dime_nxt;
      r_gap       <= w_gap_nxt;
      r_n_pulse   <= w_issue && !r_slot_dime;
      r_d_pulse   <= w_issue && r_slot_dime;
      r_rej       <= w_rej_nxt;
    end
  end

  assign N   = r_n_pulse;
  assign D   = r_d_pulse;
  assign rej = r_rej;

`ifdef COIN_COUNT_EN
  logic [7:0] r_n_count;
  logic [7:0] r_d_count;

  // Saturating credit counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_n_count <= 8'd0;
      r_d_count <= 8'd0;
    end else if (clear_cnt) begin
      r_n_count <= 8'd0;
      r_d_count <= 8'd0;
    end else begin
      if (w_issue && !r_slot_dime && (r_n_count != 8'hFF)) begin
        r_n_count <= r_n_count + 8'd1;
      end
      if (w_issue && r_slot_dime && (r_d_count != 8'hFF)) begin
        r_d_count <= r_d_count + 8'd1;
      end
    end
  end

  assign n_count = r_n_count;
  assign d_count = r_d_count;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed table-driven bench for coin_acceptor
module tb_coin_acceptor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic n_raw, d_raw, N, D, rej;
  logic n2_raw, d2_raw, N2, D2, rej2;
`ifdef COIN_COUNT_EN
  logic       clear_cnt;
  logic [7:0] n_count, d_count, n_count2, d_count2;
`endif

  coin_acceptor u_dut (
    .clk       (clk),
    .rst       (rst),
`ifdef COIN_COUNT_EN
    .clear_cnt (clear_cnt),
    .n_count   (n_count),
    .d_count   (d_count),
`endif
    .n_raw     (n_raw),
    .d_raw     (d_raw),
    .N         (N),
    .D         (D),
    .rej       (rej)
  );

  // Long gap instance: makes the slot-full drop reachable with real debounce spacing.
  coin_acceptor #(.DEB_CYCLES(4), .GAP(16)) u_dut_gap (
    .clk       (clk),
    .rst       (rst),
`ifdef COIN_COUNT_EN
    .clear_cnt (clear_cnt),
    .n_count   (n_count2),
    .d_count   (d_count2),
`endif
    .n_raw     (n2_raw),
    .d_raw     (d2_raw),
    .N         (N2),
    .D         (D2),
    .rej       (rej2)
  );

  typedef struct {
    logic n;
    logic d;
    logic en;
    logic ed;
    logic er;
  } vec_t;

  vec_t tbl [256];
  int   ntbl   = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic seg(input int len, input logic n, input logic d);
    for (int i = 0; i < len; i++) begin
      tbl[ntbl] = '{n, d, 1'b0, 1'b0, 1'b0};
      ntbl++;
    end
  endtask

  task automatic step_check_zero(input string tag, input int k);
    @(posedge clk);
    #1;
    check($sformatf("%s%0d_N", tag, k), {7'd0, N}, 8'd0);
    check($sformatf("%s%0d_D", tag, k), {7'd0, D}, 8'd0);
    check($sformatf("%s%0d_rej", tag, k), {7'd0, rej}, 8'd0);
  endtask

  initial begin
    int base;

    // Single nickel held 10 cycles: N after edge 7 only.
    base = ntbl; seg(10, 1'b1, 1'b0); seg(10, 1'b0, 1'b0);
    tbl[base + 7].en = 1'b1;
    // Dime shorter than the debounce window: nothing.
    seg(3, 1'b0, 1'b1); seg(8, 1'b0, 1'b0);
    // Dime held exactly DEB_CYCLES: accepted.
    base = ntbl; seg(4, 1'b0, 1'b1); seg(10, 1'b0, 1'b0);
    tbl[base + 7].ed = 1'b1;
    // Dime toggling every cycle: nothing.
    for (int i = 0; i < 20; i++) seg(1, 1'b0, (i % 2) == 0);
    seg(8, 1'b0, 1'b0);
    // Both coins on the same edge: one reject, no credit.
    base = ntbl; seg(10, 1'b1, 1'b1); seg(10, 1'b0, 1'b0);
    tbl[base + 6].er = 1'b1;
    // Dime then nickel one edge later: D at 7, N at 10.
    base = ntbl; seg(1, 1'b0, 1'b1); seg(9, 1'b1, 1'b1); seg(1, 1'b1, 1'b0); seg(10, 1'b0, 1'b0);
    tbl[base + 7].ed = 1'b1;
    tbl[base + 10].en = 1'b1;

    rst = 1'b0;
    n_raw = 1'b0; d_raw = 1'b0; n2_raw = 1'b0; d2_raw = 1'b0;
`ifdef COIN_COUNT_EN
    clear_cnt = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_N", {7'd0, N}, 8'd0);
    check("reset_D", {7'd0, D}, 8'd0);
    check("reset_rej", {7'd0, rej}, 8'd0);
    check("reset_N2", {7'd0, N2}, 8'd0);
    rst = 1'b1;

    for (int i = 0; i < ntbl; i++) begin
      n_raw = tbl[i].n;
      d_raw = tbl[i].d;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_N", i), {7'd0, N}, {7'd0, tbl[i].en});
      check($sformatf("tbl%0d_D", i), {7'd0, D}, {7'd0, tbl[i].ed});
      check($sformatf("tbl%0d_rej", i), {7'd0, rej}, {7'd0, tbl[i].er});
    end
`ifdef COIN_COUNT_EN
    check("n_count_after_tbl", n_count, 8'd2);
    check("d_count_after_tbl", d_count, 8'd2);
    clear_cnt = 1'b1;
    @(posedge clk);
    #1;
    clear_cnt = 1'b0;
    check("n_count_clear", n_count, 8'd0);
    check("d_count_clear", d_count, 8'd0);
`endif

    // Long-gap instance: dime, nickel accepted while dime issues, nickel re-inserted while slot full.
    for (int k = 0; k < 40; k++) begin
      d2_raw = (k <= 20);
      n2_raw = ((k >= 1) && (k <= 6)) || ((k >= 12) && (k <= 25));
      @(posedge clk);
      #1;
      check($sformatf("gap%0d_N", k), {7'd0, N2}, {7'd0, (k == 24)});
      check($sformatf("gap%0d_D", k), {7'd0, D2}, {7'd0, (k == 7)});
      check($sformatf("gap%0d_rej", k), {7'd0, rej2}, {7'd0, (k == 18)});
    end
    n2_raw = 1'b0; d2_raw = 1'b0;

    // Reset while a nickel is still debouncing: the coin is lost.
    n_raw = 1'b1;
    for (int k = 0; k < 4; k++) step_check_zero("rstmid", k);
    rst = 1'b0;
    #1;
    check("rst_async_N", {7'd0, N}, 8'd0);
    @(posedge clk);
    #1;
    n_raw = 1'b0;
    check("rst_hold_rej", {7'd0, rej}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 15; k++) step_check_zero("rstpost", k);
`ifdef COIN_COUNT_EN
    check("n_count_after_rst", n_count, 8'd0);
`endif

    // Sensor held high across reset release is a fresh coin debounced from LOW.
    n_raw = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("relhigh%0d_N", k), {7'd0, N}, {7'd0, (k == 7)});
      check($sformatf("relhigh%0d_D", k), {7'd0, D}, 8'd0);
      check($sformatf("relhigh%0d_rej", k), {7'd0, rej}, 8'd0);
    end
    n_raw = 1'b0;
    for (int k = 0; k < 10; k++) step_check_zero("relfall", k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Upstream front end for the vending-machine FSM.
- Converts two raw, asynchronous, bouncy coin-sensor lines (nickel, dime) into clean single-cycle N/D pulses on the FSM clock.
- Spaces pulses so the FSM never misses one while it sits in a dispense or change state, and flags coins it cannot credit.

Parameters:
- DEB_CYCLES, 4, consecutive synchronized cycles a sensor level must hold to be accepted. Legal range ≥ 2.
- GAP, 2, minimum idle cycles forced between any two output pulses. Legal range ≥ 1.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- n_raw, input, 1, nickel sensor; asynchronous, active-high, bouncy.
- d_raw, input, 1, dime sensor; asynchronous, active-high, bouncy.
- N, output, 1, one-cycle nickel credit pulse to the FSM; registered.
- D, output, 1, one-cycle dime credit pulse to the FSM; registered.
- rej, output, 1, one-cycle pulse meaning a coin was detected but not credited; registered.

Behaviour:
- Reset: rst low clears, immediately and asynchronously, all synchronizers, debounce states and counters, the pending slot and the gap counter. N, D and rej all read 0.
- Synchronizer: two flops per raw input. s_x is the raw input delayed 2 edges.
- Debounce FSM, one per channel:
  - LOW, s_x=1: go to RISE, cnt=1.
  - RISE, s_x=0: go to LOW.
  - RISE, cnt==DEB_CYCLES-1: go to HIGH and raise the one-cycle internal strobe q_x.
  - RISE, otherwise: cnt++.
  - HIGH, s_x=0: go to FALL, cnt=1.
  - FALL, s_x=1: go to HIGH; no new strobe.
  - FALL, cnt==DEB_CYCLES-1: go to LOW.
  - FALL, otherwise: cnt++.
  - Result: exactly one strobe per clean coin. Pulses shorter than DEB_CYCLES synchronized cycles produce nothing. A bounce on release never re-strobes.
- Arbitration on the strobes, registered into the pending slot (1-deep, holds coin type):
  - q_n and q_d in the same cycle: rej pulses next cycle; neither coin is credited.
  - One strobe with the slot empty, or with the slot being issued this cycle: the coin enters the slot.
  - One strobe with the slot full and not issuing: rej pulses next cycle; the new coin is dropped and the slot is unchanged.
- Issue:
  - When the slot is full and gap_cnt==0, assert N or D for exactly one cycle, empty the slot and load gap_cnt=GAP.
  - gap_cnt decrements to 0 each cycle.
  - Consecutive credit pulses are therefore separated by ≥ GAP low cycles.
- Latency: let edge 0 be the first edge sampling raw=1 on an idle channel with no gap pending. N/D is high for the cycle after edge DEB_CYCLES+3, which is edge 7 at defaults.
- Mutual exclusion: N and D are never high together. rej may coincide with N or D.
- Reset mid-operation: any in-flight or pending coin is lost; no pulse is emitted after release for it. A sensor still high at reset release is debounced from LOW as a new coin.
- Counter widths: cnt is clog2(DEB_CYCLES) bits; gap_cnt is clog2(GAP+1) bits. No wrap-around is possible in legal ranges.

Optional Feature:
- Macro COIN_COUNT_EN.
- Defined:
  - Adds outputs n_count[7:0] and d_count[7:0].
  - Each increments on its issued N or D pulse and saturates at 255.
  - Both reset to 0.
  - Adds a clear_cnt input (1 bit, synchronous, active-high) that zeroes both counters. clear has priority over an increment in the same cycle.
- Undefined: these ports and counters do not exist; the core behaviour is identical.

Test Plan:
- Defaults; n_raw high 10 cycles from edge 0 → N high exactly at cycle after edge 7; D=0 and rej=0 throughout; no further pulse after n_raw falls.
- d_raw high 3 cycles, then low; and separately d_raw toggling every cycle for 20 cycles → no D, no rej.
- n_raw and d_raw rise on the same edge, held 10 cycles → rej high for one cycle at cycle after edge 6; N and D never asserted.
- d_raw rises at edge 0 and n_raw at edge 1, both held 10 cycles → D after edge 7, N after edge 10 (2 low cycles between); rej=0.
- Three channels-worth of strobes back to back (dime, then nickel 1 cycle later, then nickel re-inserted after release while the slot is still full) → first two credited with GAP spacing; third gives rej=1 and no credit.
- n_raw high 5 cycles, rst pulsed low at edge 4 for 2 cycles while n_raw returns low → N, D, rej stay 0 through and after reset; with COIN_COUNT_EN, n_count remains 0.
